// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift register sequencer: FSM states, direction codes and
// the default data width.
package shift_seq_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Command direction codes carried on cmd_dir
    localparam logic [1:0] DIR_LOAD  = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_RIGHT = 2'b10;
    localparam logic [1:0] DIR_ILL   = 2'b11;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StLoad  = 2'b01,
        StShift = 2'b10,
        StResp  = 2'b11
    } state_e;

endpackage

// File: rtl/shift_seq_counter.sv
// Loadable down-counter with a zero flag; the sequencer loads it with (count - 1) on
// entry to SHIFT and leaves SHIFT on the cycle the flag is set.
module shift_seq_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Next count: load has priority, decrement stops at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register, synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/shift_reg_sequencer.sv
// Command-driven controller for an 8-bit universal shift register: accepts a
// (data, dir, count) command, loads the register, issues count one-bit shift strobes,
// captures the result and returns it over a valid/ready response channel.
// Optional: define SHIFT_SEQ_PERF_EN to add perf_cmd_done_o (completed responses).
module shift_reg_sequencer
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [WIDTH-1:0] cmd_data_i,
    input  logic [1:0]       cmd_dir_i,
    input  logic [CNT_W-1:0] cmd_count_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic             rsp_err_o,
    output logic             busy_o,
    output logic             sr_load_o,
    output logic             sr_shift_left_o,
    output logic             sr_shift_right_o,
    output logic [WIDTH-1:0] sr_parallel_in_o,
`ifdef SHIFT_SEQ_PERF_EN
    output logic [15:0]      perf_cmd_done_o,
`endif
    input  logic [WIDTH-1:0] sr_parallel_out_i
);

    state_e           state_d, state_q;
    logic [WIDTH-1:0] data_d, data_q;
    logic [1:0]       dir_d, dir_q;
    logic [CNT_W-1:0] count_d, count_q;
    logic             rsp_valid_d, rsp_valid_q;
    logic [WIDTH-1:0] rsp_data_d, rsp_data_q;
    logic             rsp_err_d, rsp_err_q;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic             dir_shifts;

    assign dir_shifts = (dir_q == DIR_LEFT) || (dir_q == DIR_RIGHT);

    shift_seq_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (cnt_load),
        .load_val_i (count_q - 1'b1),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Next-state logic; the response is captured one cycle after the last strobe so
    // the register has already absorbed it
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        dir_d       = dir_q;
        count_d     = count_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    data_d  = cmd_data_i;
                    dir_d   = cmd_dir_i;
                    count_d = (cmd_count_i > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd_count_i;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (dir_shifts && (count_q != '0)) begin
                    cnt_load = 1'b1;
                    state_d  = StShift;
                end else begin
                    state_d = StResp;
                end
            end
            StShift: begin
                if (cnt_zero) begin
                    state_d = StResp;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StResp: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = sr_parallel_out_i;
                    rsp_err_d   = (dir_q == DIR_ILL);
                end else if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers, synchronous reset drops any pending response
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            data_q      <= '0;
            dir_q       <= DIR_LOAD;
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            dir_q       <= dir_d;
            count_q     <= count_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef SHIFT_SEQ_PERF_EN
    logic [15:0] perf_q;

    // Completed response handshakes, wraps naturally at 16 bits
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            perf_q <= '0;
        end else if (rsp_valid_q && rsp_ready_i) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_cmd_done_o = perf_q;
`endif

    // Strobes decode only registered state, so no command input reaches sr_* directly
    assign cmd_ready_o      = (state_q == StIdle);
    assign busy_o           = (state_q != StIdle);
    assign sr_load_o        = (state_q == StLoad);
    assign sr_shift_left_o  = (state_q == StShift) && (dir_q == DIR_LEFT);
    assign sr_shift_right_o = (state_q == StShift) && (dir_q == DIR_RIGHT);
    assign sr_parallel_in_o = data_q;
    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_data_o       = rsp_data_q;
    assign rsp_err_o        = rsp_err_q;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed bench for shift_reg_sequencer with a behavioural universal shift register.
module tb_shift_reg_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [W-1:0] cmd_data = '0;
    logic [1:0]   cmd_dir = '0;
    logic [3:0]   cmd_count = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_data;
    logic         rsp_err;
    logic         busy;
    logic         sr_load, sr_left, sr_right;
    logic [W-1:0] sr_pin;
    logic [W-1:0] sr_q = '0;
`ifdef SHIFT_SEQ_PERF_EN
    logic [15:0]  perf;
`endif

    int checks = 0;
    int errors = 0;
    int onehot_viol = 0;
    int n_done = 0;

    always #5 clk = ~clk;

    shift_reg_sequencer u_dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .cmd_valid_i       (cmd_valid),
        .cmd_ready_o       (cmd_ready),
        .cmd_data_i        (cmd_data),
        .cmd_dir_i         (cmd_dir),
        .cmd_count_i       (cmd_count),
        .rsp_valid_o       (rsp_valid),
        .rsp_ready_i       (rsp_ready),
        .rsp_data_o        (rsp_data),
        .rsp_err_o         (rsp_err),
        .busy_o            (busy),
        .sr_load_o         (sr_load),
        .sr_shift_left_o   (sr_left),
        .sr_shift_right_o  (sr_right),
        .sr_parallel_in_o  (sr_pin),
`ifdef SHIFT_SEQ_PERF_EN
        .perf_cmd_done_o   (perf),
`endif
        .sr_parallel_out_i (sr_q)
    );

    // Universal shift register model: load, or shift with zero fill
    always @(posedge clk) begin
        if (sr_load)       sr_q <= sr_pin;
        else if (sr_left)  sr_q <= {sr_q[W-2:0], 1'b0};
        else if (sr_right) sr_q <= {1'b0, sr_q[W-1:1]};
    end

    // Strobe exclusivity monitored on every cycle of every test
    always @(negedge clk) begin
        if ((int'(sr_load) + int'(sr_left) + int'(sr_right)) > 1) onehot_viol++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one command, measure accept->rsp_valid latency, optionally stall, then consume
    task automatic run_cmd(input string tag, input logic [7:0] data, input logic [1:0] dir,
                           input logic [3:0] cnt, input logic [7:0] exp_data,
                           input logic exp_err, input int exp_lat, input int stall);
        int lat;
        int guard;
        @(negedge clk);
        cmd_data  = data;
        cmd_dir   = dir;
        cmd_count = cnt;
        cmd_valid = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_ready"}, cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_data"}, rsp_data, exp_data);
        check({tag, "_err"}, rsp_err, exp_err);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, rsp_valid, 1);
            check({tag, "_hold_data"}, rsp_data, exp_data);
            check({tag, "_hold_cmdrdy"}, cmd_ready, 0);
            check({tag, "_hold_strobes"}, {sr_load, sr_left, sr_right}, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        n_done++;
        check({tag, "_done_valid"}, rsp_valid, 0);
        check({tag, "_done_idle"}, {busy, cmd_ready}, 2'b01);
    endtask

    initial begin
        bit seen_rsp;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_outputs", {rsp_valid, rsp_err, busy, sr_load, sr_left, sr_right}, 0);
        check("rst_rsp_data", rsp_data, 0);
`ifdef SHIFT_SEQ_PERF_EN
        check("rst_perf", perf, 0);
`endif
        reset = 1'b0;

        run_cmd("left1",    8'hE5, 2'b01, 4'd1,  8'hCA, 1'b0, 3,  0);
        run_cmd("right1",   8'hE5, 2'b10, 4'd1,  8'h72, 1'b0, 3,  0);
        run_cmd("left3",    8'hE5, 2'b01, 4'd3,  8'h28, 1'b0, 5,  0);
        run_cmd("right8",   8'hE5, 2'b10, 4'd8,  8'h00, 1'b0, 10, 0);
        run_cmd("cnt0",     8'hE5, 2'b01, 4'd0,  8'hE5, 1'b0, 2,  0);
        run_cmd("loadonly", 8'hE5, 2'b00, 4'd5,  8'hE5, 1'b0, 2,  0);
        run_cmd("illegal",  8'hE5, 2'b11, 4'd3,  8'hE5, 1'b1, 2,  0);
        run_cmd("stall",    8'h81, 2'b10, 4'd2,  8'h20, 1'b0, 4,  3);
        // Count 15 saturates to 8: 0xFF fully cleared, latency 10 rather than 17
        run_cmd("sat",      8'hFF, 2'b01, 4'd15, 8'h00, 1'b0, 10, 0);

        // Reset during the third SHIFT cycle of a count-6 command
        @(negedge clk);
        cmd_data  = 8'hE5;
        cmd_dir   = 2'b01;
        cmd_count = 4'd6;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_shifting", {busy, sr_left}, 2'b11);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_idle", {busy, cmd_ready}, 2'b01);
        check("mid_rst_strobes", {sr_load, sr_left, sr_right}, 0);
        check("mid_rst_rsp", rsp_valid, 0);
        reset = 1'b0;
        seen_rsp = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid || busy) seen_rsp = 1'b1;
        end
        check("mid_rst_no_rsp", seen_rsp, 0);

        run_cmd("post_rst", 8'h0F, 2'b01, 4'd4, 8'hF0, 1'b0, 6, 0);

`ifdef SHIFT_SEQ_PERF_EN
        check("perf_count", perf, n_done);
`endif
        check("strobe_onehot", onehot_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
